aes_block_deserializer: RTL and testbench



---
 rtl/aes_block_deserializer.sv | 142 ++++++++++++++
 tb/tb_aes_block_deserializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_deserializer.sv
// Packs a byte stream into 128-bit AES ciphertext blocks (first byte in the MSB) behind
// a double buffer. Optional idle timeout for partial blocks is enabled by DESER_TIMEOUT_EN.
module aes_block_deserializer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    output logic [127:0] block_out,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_last,
    output logic         err_partial,
    output logic         err_timeout
);

    logic [3:0]   cnt_reg, cnt_next;
    logic [127:0] asm_reg, asm_next;
    logic         asm_full_reg, asm_full_next;
    logic         asm_last_reg, asm_last_next;
    logic [127:0] out_reg, out_next;
    logic         out_valid_reg, out_valid_next;
    logic         out_last_reg, out_last_next;
    logic         err_partial_reg, err_partial_next;

    logic         accept;
    logic         drain;
    logic         complete;
    logic         to_hit;
    logic [127:0] asm_merged;

    assign in_ready    = !asm_full_reg;
    assign block_out   = out_reg;
    assign block_valid = out_valid_reg;
    assign block_last  = out_last_reg;
    assign err_partial = err_partial_reg;

    assign accept   = in_valid && !asm_full_reg;
    assign drain    = out_valid_reg && block_ready;
    assign complete = accept && ((cnt_reg == 4'd15) || in_last);
    // Unwritten bytes of the assembly register are always zero, so OR-ing in the new byte
    // also yields the zero-padded short block.
    assign asm_merged = asm_reg | ({in_data, 120'b0} >> {cnt_reg, 3'b000});

`ifdef DESER_TIMEOUT_EN
    logic [TO_W-1:0] to_reg;
    logic            err_timeout_reg;

    assign to_hit      = !accept && (cnt_reg != 4'd0) && !asm_full_reg &&
                         (to_reg == TO_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_timeout_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_reg          <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            err_timeout_reg <= to_hit;
            if (accept || (cnt_reg == 4'd0) || asm_full_reg || to_hit)
                to_reg <= '0;
            else
                to_reg <= to_reg + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYCLES > 0) && (TO_W > 0);
    assign to_hit      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        cnt_next         = cnt_reg;
        asm_next         = asm_reg;
        asm_full_next    = asm_full_reg;
        asm_last_next    = asm_last_reg;
        out_next         = out_reg;
        out_valid_next   = out_valid_reg;
        out_last_next    = out_last_reg;
        err_partial_next = 1'b0;

        if (drain) begin
            if (asm_full_reg) begin
                out_next      = asm_reg;
                out_last_next = asm_last_reg;
                asm_full_next = 1'b0;
                asm_next      = '0;
            end else begin
                out_valid_next = 1'b0;
            end
        end

        // A completing byte can never coincide with a pending asm_full block (in_ready is low).
        if (complete) begin
            err_partial_next = (cnt_reg != 4'd15);
            cnt_next         = 4'd0;
            if (!out_valid_reg || drain) begin
                out_next       = asm_merged;
                out_last_next  = in_last;
                out_valid_next = 1'b1;
                asm_next       = '0;
            end else begin
                asm_next      = asm_merged;
                asm_last_next = in_last;
                asm_full_next = 1'b1;
            end
        end else if (accept) begin
            asm_next = asm_merged;
            cnt_next = cnt_reg + 4'd1;
        end else if (to_hit) begin
            asm_next = '0;
            cnt_next = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg         <= 4'd0;
            asm_reg         <= '0;
            asm_full_reg    <= 1'b0;
            asm_last_reg    <= 1'b0;
            out_reg         <= '0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            err_partial_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            asm_reg         <= asm_next;
            asm_full_reg    <= asm_full_next;
            asm_last_reg    <= asm_last_next;
            out_reg         <= out_next;
            out_valid_reg   <= out_valid_next;
            out_last_reg    <= out_last_next;
            err_partial_reg <= err_partial_next;
        end
    end

endmodule

// File: tb/tb_aes_block_deserializer.sv
// Randomized and directed bench for aes_block_deserializer, checked against a
// queue-based model of completed-but-undelivered blocks.
module tb_aes_block_deserializer;

`ifdef DESER_TIMEOUT_EN
    localparam int TB_TO  = 8;
    localparam int TB_TOW = 4;
`else
    localparam int TB_TO  = 4096;
    localparam int TB_TOW = 13;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_last = 1'b0;
    logic [127:0] block_out;
    logic         block_valid;
    logic         block_ready = 1'b0;
    logic         block_last;
    logic         err_partial;
    logic         err_timeout;

    aes_block_deserializer #(.TIMEOUT_CYCLES(TB_TO), .TO_W(TB_TOW)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .block_out(block_out), .block_valid(block_valid), .block_ready(block_ready),
        .block_last(block_last), .err_partial(err_partial), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Model: bytes of the frame in progress, and blocks completed but not yet taken.
    logic [7:0]   cur[$];
    logic [127:0] exp_q[$];
    bit           exp_ql[$];
    bit           exp_partial;
    bit           exp_to;
    int           idle;
    bit           accepted;
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(string tag, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_cur();
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < cur.size(); i++) b[127-8*i -: 8] = cur[i];
        return b;
    endfunction

    task automatic check_outputs();
        check("in_ready", in_ready, exp_q.size() < 2);
        check("block_valid", block_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("block_out", block_out, exp_q[0]);
            check("block_last", block_last, exp_ql[0]);
        end
        check("err_partial", err_partial, exp_partial);
        check("err_timeout", err_timeout, exp_to);
    endtask

    task automatic step(logic v, logic [7:0] d, logic l, logic r);
        int pend;
        in_valid = v; in_data = d; in_last = l; block_ready = r;
        @(posedge clk);
        pend        = exp_q.size();
        accepted    = v && (pend < 2);
        exp_partial = 1'b0;
        exp_to      = 1'b0;
`ifdef DESER_TIMEOUT_EN
        if (accepted || cur.size() == 0 || pend == 2) idle = 0;
        else begin
            idle++;
            if (idle == TB_TO) begin
                cur.delete();
                idle   = 0;
                exp_to = 1'b1;
            end
        end
`endif
        if (r && pend > 0) begin
            void'(exp_q.pop_front());
            void'(exp_ql.pop_front());
        end
        if (accepted) begin
            cur.push_back(d);
            if (cur.size() == 16 || l) begin
                exp_partial = (cur.size() < 16);
                exp_q.push_back(pack_cur());
                exp_ql.push_back(l);
                cur.delete();
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic put(logic [7:0] d, logic l, logic r);
        int n;
        n = 0;
        do begin
            step(1'b1, d, l, r);
            n++;
        end while (!accepted && n < 200);
        check("put_bound", accepted, 1'b1);
    endtask

    task automatic model_clear();
        cur.delete(); exp_q.delete(); exp_ql.delete();
        exp_partial = 1'b0; exp_to = 1'b0; idle = 0;
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_valid"}, block_valid, 1'b0);
        check({tag, "_out"}, block_out, 128'h0);
        check({tag, "_last"}, block_last, 1'b0);
        check({tag, "_partial"}, err_partial, 1'b0);
        check({tag, "_timeout"}, err_timeout, 1'b0);
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_state("rst0");
        reset = 1'b1;

        // Back-to-back 16 bytes with the decryptor ready
        for (int i = 0; i < 16; i++) put(8'(i), 1'b0, 1'b1);
        check("t1_valid", block_valid, 1'b1);
        check("t1_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("t1_last", block_last, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Two blocks pile up while the decryptor stalls
        for (int i = 0; i < 32; i++) put(8'(i), 1'b0, 1'b0);
        check("t2_in_ready_low", in_ready, 1'b0);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        check("t2_held_off", accepted, 1'b0);
        check("t2_first", block_out, 128'h000102030405060708090A0B0C0D0E0F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_second", block_out, 128'h101112131415161718191A1B1C1D1E1F);
        check("t2_no_gap", block_valid, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_in_ready_back", in_ready, 1'b1);

        // Short frame of 5 bytes
        for (int i = 0; i < 5; i++) put(8'hAA, i == 4, 1'b1);
        check("t3_block", block_out, 128'hAAAAAAAAAA0000000000000000000000);
        check("t3_last", block_last, 1'b1);
        check("t3_partial", err_partial, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // in_last on the 16th byte, then a fresh frame
        for (int i = 0; i < 16; i++) put(8'(8'h40 + i), i == 15, 1'b1);
        check("t4_last", block_last, 1'b1);
        check("t4_partial", err_partial, 1'b0);
        for (int i = 0; i < 16; i++) put(8'(8'h50 + i), 1'b0, 1'b1);
        check("t4_next_msb", block_out[127:120], 8'h50);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Partial block followed by idle time
        for (int i = 0; i < 3; i++) put(8'(8'hE0 + i), 1'b0, 1'b1);
`ifdef DESER_TIMEOUT_EN
        repeat (10) step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) put(8'(8'h10 + i), 1'b0, 1'b1);
        check("t5_after_timeout", block_out, 128'h101112131415161718191A1B1C1D1E1F);
`else
        repeat (20) step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) put(8'(8'h10 + i), 1'b0, 1'b1);
        check("t5_held_partial", block_out, 128'hE0E1E2101112131415161718191A1B1C);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset with a full block in the output register and 7 bytes assembled
        for (int i = 0; i < 23; i++) put(8'(8'h60 + i), 1'b0, 1'b0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_state("rst_mid");
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) put(8'(8'h80 + i), 1'b0, 1'b1);
        check("t6_block", block_out, 128'h808182838485868788898A8B8C8D8E8F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
